// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator: syncs, active flag, circle mask, coordinates.
interface vga_timing_gen_if;
    logic       HS;
    logic       VS;
    logic       active;
    logic       vidSel;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       frame_start;

    modport master (
        output HS,
        output VS,
        output active,
        output vidSel,
        output hcount,
        output vcount,
        output frame_start
    );

    modport slave (
        input HS,
        input VS,
        input active,
        input vidSel,
        input hcount,
        input vcount,
        input frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: clock divider, h/v counters and a registered decode stage
// producing syncs, active video, an in-circle mask and a frame-start pulse.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned RADIUS    = 200
) (
    input logic               clk100,
    input logic               reset_n,
    vga_timing_gen_if.master  vga_o
);

    localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DivW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [9:0] HLast   = 10'(HTotal - 1);
    localparam logic [9:0] VLast   = 10'(VTotal - 1);
    localparam logic [9:0] HVis    = 10'(H_VISIBLE);
    localparam logic [9:0] VVis    = 10'(V_VISIBLE);
    localparam logic [9:0] HsStart = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HsEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VsStart = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VsEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic signed [10:0] CentreX = 11'(H_VISIBLE / 2);
    localparam logic signed [10:0] CentreY = 11'(V_VISIBLE / 2);
    localparam logic [19:0]        RadSq   = 20'(RADIUS * RADIUS);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      hcount_q, hcount_d;
    logic [9:0]      vcount_q, vcount_d;
    logic            wrap_q, wrap_d;
    logic            tick;

    logic hs_q, hs_d;
    logic vs_q, vs_d;
    logic active_q, active_d;
    logic vid_q, vid_d;
    logic fs_q, fs_d;

    logic signed [10:0] dx, dy;
    logic [10:0]        dx_mag, dy_mag;
    logic [19:0]        dx_sq, dy_sq, dist_sq;

    assign tick = (div_q == DivLast);

    // Counters only move on the pixel tick; wrap_d flags the (last,last) -> (0,0) step.
    always_comb begin
        div_d    = div_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        wrap_d   = 1'b0;
        if (tick) begin
            div_d = '0;
            if (hcount_q == HLast) begin
                hcount_d = '0;
                if (vcount_q == VLast) begin
                    vcount_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end else begin
            div_d = div_q + DivW'(1);
        end
    end

    // Offsets from the circle centre; squares taken on magnitudes to stay unsigned.
    assign dx      = $signed({1'b0, hcount_q}) - CentreX;
    assign dy      = $signed({1'b0, vcount_q}) - CentreY;
    assign dx_mag  = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    assign dy_mag  = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    assign dx_sq   = {9'd0, dx_mag} * {9'd0, dx_mag};
    assign dy_sq   = {9'd0, dy_mag} * {9'd0, dy_mag};
    assign dist_sq = dx_sq + dy_sq;

    always_comb begin
        active_d = (hcount_q < HVis) && (vcount_q < VVis);
        hs_d     = !((hcount_q >= HsStart) && (hcount_q < HsEnd));
        vs_d     = !((vcount_q >= VsStart) && (vcount_q < VsEnd));
        vid_d    = active_d && (dist_sq < RadSq);
        fs_d     = wrap_q;
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            wrap_q   <= wrap_d;
        end
    end

    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            active_q <= 1'b0;
            vid_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            active_q <= active_d;
            vid_q    <= vid_d;
            fs_q     <= fs_d;
        end
    end

    assign vga_o.HS          = hs_q;
    assign vga_o.VS          = vs_q;
    assign vga_o.active      = active_q;
    assign vga_o.vidSel      = vid_q;
    assign vga_o.hcount      = hcount_q;
    assign vga_o.vcount      = vcount_q;
    assign vga_o.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: cycle scoreboard on a short-frame instance plus timing and mask
// checks, and a second instance with CLK_DIV=2, RADIUS=100.
module tb_vga_timing_gen;

    localparam int ADiv  = 4;
    localparam int HTot  = 800;
    localparam int VVis  = 2;
    localparam int VFp   = 1;
    localparam int VSyn  = 2;
    localparam int VBp   = 1;
    localparam int VTot  = VVis + VFp + VSyn + VBp;
    localparam int Line  = HTot * ADiv;
    localparam int Frame = VTot * Line;

    logic clk100  = 1'b0;
    logic reset_n = 1'b0;

    vga_timing_gen_if a_if ();
    vga_timing_gen_if b_if ();

    vga_timing_gen #(
        .CLK_DIV   (ADiv),
        .V_VISIBLE (VVis),
        .V_FP      (VFp),
        .V_SYNC    (VSyn),
        .V_BP      (VBp)
    ) u_dut_a (
        .clk100  (clk100),
        .reset_n (reset_n),
        .vga_o   (a_if.master)
    );

    vga_timing_gen #(
        .CLK_DIV   (2),
        .RADIUS    (100),
        .V_VISIBLE (VVis),
        .V_FP      (VFp),
        .V_SYNC    (VSyn),
        .V_BP      (VBp)
    ) u_dut_b (
        .clk100  (clk100),
        .reset_n (reset_n),
        .vga_o   (b_if.master)
    );

    always #5 clk100 = ~clk100;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk100) begin
        if (!reset_n) cyc = 0;
        else          cyc++;
    end

    // Scoreboard: reference raster model for instance A, one expected record per clock.
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       act;
        logic       vid;
        logic       fs;
    } obs_t;

    obs_t exp_q[$];
    int   m_div = 0, m_h = 0, m_v = 0;
    bit   m_wrap = 0;

    function automatic obs_t model_decode(input int h, input int v, input bit wrap);
        obs_t e;
        int   ddx, ddy;
        ddx   = h - 320;
        ddy   = v - VVis / 2;
        e     = '0;
        e.hs  = !(h >= 656 && h < 752);
        e.vs  = !(v >= VVis + VFp && v < VVis + VFp + VSyn);
        e.act = (h < 640) && (v < VVis);
        e.vid = e.act && (ddx * ddx + ddy * ddy < 200 * 200);
        e.fs  = wrap;
        return e;
    endfunction

    always @(posedge clk100) begin
        if (!reset_n) begin
            m_div  = 0;
            m_h    = 0;
            m_v    = 0;
            m_wrap = 0;
            exp_q.delete();
        end else begin
            obs_t e;
            e      = model_decode(m_h, m_v, m_wrap);
            m_wrap = 0;
            if (m_div == ADiv - 1) begin
                m_div = 0;
                if (m_h == HTot - 1) begin
                    m_h = 0;
                    if (m_v == VTot - 1) begin
                        m_v    = 0;
                        m_wrap = 1;
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end else begin
                m_div++;
            end
            e.h = 10'(m_h);
            e.v = 10'(m_v);
            exp_q.push_back(e);
        end
    end

    always @(negedge clk100) begin
        if (reset_n && exp_q.size() > 0) begin
            obs_t e, g;
            e = exp_q.pop_front();
            g = '{h: a_if.hcount, v: a_if.vcount, hs: a_if.HS, vs: a_if.VS,
                  act: a_if.active, vid: a_if.vidSel, fs: a_if.frame_start};
            check_eq("raster", 32'(g), 32'(e));
        end
    end

    // frame_start pulse log and counter range tracking for instance A.
    int fs_times[$];
    int fs_high = 0;
    bit fs_prev = 0;
    int hmax = 0, vmax = 0;

    always @(negedge clk100) begin
        if (reset_n) begin
            if (a_if.frame_start) begin
                fs_high++;
                if (!fs_prev) fs_times.push_back(cyc);
            end
            fs_prev = a_if.frame_start;
            if (int'(a_if.hcount) > hmax) hmax = int'(a_if.hcount);
            if (int'(a_if.vcount) > vmax) vmax = int'(a_if.vcount);
        end
    end

    function automatic logic sig_val(input int sel);
        case (sel)
            0:       return a_if.HS;
            1:       return a_if.VS;
            2:       return a_if.active;
            3:       return a_if.frame_start;
            default: return b_if.HS;
        endcase
    endfunction

    // Returns the cycle at which the selected signal transitions to lvl.
    task automatic wait_sig(input int sel, input logic lvl, input int budget, output int t);
        logic prev, cur;
        t    = -1;
        prev = sig_val(sel);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk100);
            cur = sig_val(sel);
            if (prev !== lvl && cur === lvl) begin
                t = cyc;
                return;
            end
            prev = cur;
        end
        check_eq($sformatf("timeout_sig%0d", sel), 0, 1);
    endtask

    task automatic wait_pix(input int dut, input int h, input int v, input int budget,
                            output int t);
        logic [9:0] hc, vc;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            hc = (dut == 0) ? a_if.hcount : b_if.hcount;
            vc = (dut == 0) ? a_if.vcount : b_if.vcount;
            if (int'(hc) == h && int'(vc) == v) begin
                t = cyc;
                return;
            end
            @(negedge clk100);
        end
        check_eq($sformatf("timeout_pix%0d_%0d_%0d", dut, h, v), 0, 1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_hs"}, 32'(a_if.HS), 1);
        check_eq({pfx, "_vs"}, 32'(a_if.VS), 1);
        check_eq({pfx, "_active"}, 32'(a_if.active), 0);
        check_eq({pfx, "_vidsel"}, 32'(a_if.vidSel), 0);
        check_eq({pfx, "_fs"}, 32'(a_if.frame_start), 0);
        check_eq({pfx, "_hcount"}, 32'(a_if.hcount), 0);
        check_eq({pfx, "_vcount"}, 32'(a_if.vcount), 0);
    endtask

    int circ_h[9] = '{0, 320, 700, 120, 121, 320, 519, 520, 700};
    int circ_v[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    int circ_e[9] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};

    initial begin
        int t, f0, f1, fs_before;
        reset_n = 1'b0;
        repeat (10) @(posedge clk100);
        #1;
        check_reset_vals("rst");
        check_eq("rst_b_hs", 32'(b_if.HS), 1);
        @(posedge clk100);
        #3 reset_n = 1'b1;
        @(posedge clk100);
        @(negedge clk100);
        check_eq("first_active", 32'(a_if.active), 1);
        check_eq("first_hcount", 32'(a_if.hcount), 0);

        fork
            begin : horiz
                int t1, t2, t3, t4, t5, tp, t6;
                wait_pix(0, 640, 0, 4000, t1);
                wait_sig(2, 1'b0, 100, t2);
                check_eq("active_fall_lag", t2 - t1, 1);
                wait_sig(0, 1'b0, 1000, t3);
                check_eq("hs_fall_first", t3, 2625);
                wait_sig(0, 1'b1, 1000, t4);
                check_eq("hs_low_width", t4 - t3, 384);
                wait_sig(2, 1'b1, 1000, t5);
                wait_pix(0, 656, 1, 4000, tp);
                wait_sig(0, 1'b0, 100, t6);
                check_eq("hs_from_line_start", t6 - t5, 2624);
                check_eq("hs_after_656", t6 - tp, 1);
                check_eq("line_period", t6 - t3, Line);
            end
            begin : vert
                int tv0, tv1;
                wait_sig(1, 1'b0, 2 * Frame, tv0);
                check_eq("vs_fall", tv0, (VVis + VFp) * Line + 1);
                wait_sig(1, 1'b1, 2 * Frame, tv1);
                check_eq("vs_low_width", tv1 - tv0, VSyn * Line);
                while (cyc < 2 * Frame + 20) @(negedge clk100);
            end
            begin : circle_a
                int tf, tc;
                wait_sig(3, 1'b1, 2 * Frame, tf);
                for (int i = 0; i < 9; i++) begin
                    wait_pix(0, circ_h[i], circ_v[i], Frame, tc);
                    @(negedge clk100);
                    check_eq($sformatf("vid_a_%0d_%0d", circ_h[i], circ_v[i]),
                             32'(a_if.vidSel), circ_e[i]);
                end
            end
            begin : dut_b
                int tb0, tb1, tc;
                wait_sig(4, 1'b0, 4000, tb0);
                check_eq("b_hs_fall_first", tb0, 656 * 2 + 1);
                wait_sig(4, 1'b0, 4000, tb1);
                check_eq("b_line_period", tb1 - tb0, 1600);
                wait_pix(1, 419, 1, 20000, tc);
                @(negedge clk100);
                check_eq("vid_b_419_1", 32'(b_if.vidSel), 1);
                wait_pix(1, 420, 1, 20, tc);
                @(negedge clk100);
                check_eq("vid_b_420_1", 32'(b_if.vidSel), 0);
            end
        join

        f0 = (fs_times.size() > 0) ? fs_times[0] : -1;
        f1 = (fs_times.size() > 1) ? fs_times[1] : -1;
        check_eq("fs_count", fs_times.size(), 2);
        check_eq("fs_first", f0, Frame + 1);
        check_eq("fs_period", f1 - f0, Frame);
        check_eq("fs_width", fs_high, 2);
        check_eq("hcount_max", hmax, HTot - 1);
        check_eq("vcount_max", vmax, VTot - 1);

        // Mid-frame reset: outputs must clear without waiting for a clock edge.
        wait_pix(0, 400, 1, Frame, t);
        check_eq("pre_rst_active", 32'(a_if.active), 1);
        #1 reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        fs_before = fs_times.size();
        repeat (3) @(posedge clk100);
        #3 reset_n = 1'b1;
        wait_sig(1, 1'b0, 2 * Frame, t);
        check_eq("vs_after_rst", t, (VVis + VFp) * Line + 1);
        check_eq("fs_after_rst", fs_times.size(), fs_before);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
